// File: rtl/mux_arbiter_2to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_arbiter_2to1_pkg
//   Shared definitions for the 2:1 round-robin arbiter: FSM state encodings and
//   the burst counter width.
// -----------------------------------------------------------------------------
package mux_arbiter_2to1_pkg;

  // Encodings are fixed so that waveforms and any external decode agree.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  // Width of the beat counter; holds MAX_BURST values up to 15.
  localparam int ARB_CNT_W = 4;

endpackage : mux_arbiter_2to1_pkg

// File: rtl/mux2_1_32bit.sv
// -----------------------------------------------------------------------------
// mux2_1_32bit
//   Plain 32-bit 2:1 data-steering multiplexer.
// Ports
//   in0 : word selected when sel = 0
//   in1 : word selected when sel = 1
//   sel : select
//   y   : steered word
// -----------------------------------------------------------------------------
module mux2_1_32bit (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sel,
  output logic [31:0] y
);

  assign y = sel ? in1 : in0;

endmodule : mux2_1_32bit

// File: rtl/mux_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// mux_arbiter_2to1
//   Shares one result path between two valid/ready requesters. Round-robin
//   grant with a bounded burst length, 2:1 data steering, and a one-entry
//   output register with a valid/ready handshake toward the consumer.
// Ports
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   req0_valid/data/ready  : requester 0 handshake; ready = beat accepted
//   req1_valid/data/ready  : requester 1 handshake; ready = beat accepted
//   out_valid/data/src     : output register contents and producing requester
//   out_ready              : consumer takes the word this cycle
//   grant_sel              : registered steering select (0 = req0, 1 = req1)
// -----------------------------------------------------------------------------
module mux_arbiter_2to1
  import mux_arbiter_2to1_pkg::*;
#(
  parameter int WIDTH     = 32,  // only 32 is supported by the steering mux
  parameter int MAX_BURST = 4    // 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             grant_sel
);

  localparam logic [ARB_CNT_W-1:0] BURST_MAX  = ARB_CNT_W'(MAX_BURST);
  localparam logic [ARB_CNT_W:0]   BURST_MAXW = (ARB_CNT_W + 1)'(MAX_BURST);

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [ARB_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                 grant_sel_q, grant_sel_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_src_q, out_src_d;

  logic                 load_en;
  logic                 xfer0, xfer1, xfer;
  logic [WIDTH-1:0]     steered_data;
  logic [ARB_CNT_W:0]   cnt_inc;
  logic                 burst_done;
  logic [ARB_CNT_W-1:0] cnt_next;

  mux2_1_32bit u_steer (
    .in0 (req0_data),
    .in1 (req1_data),
    .sel (grant_sel_q),
    .y   (steered_data)
  );

  // Readies depend only on state and output-register occupancy, never on the
  // valids, so no combinational valid->ready loop can form upstream.
  assign load_en    = !out_valid_q || out_ready;
  assign req0_ready = (state_q == ST_GNT0) && load_en;
  assign req1_ready = (state_q == ST_GNT1) && load_en;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer       = xfer0 || xfer1;

  // One-bit-wider increment so a saturated count never wraps. Using >= lets a
  // burst that saturated while the other side was idle hand over on the very
  // next beat once the other requester shows up.
  assign cnt_inc    = {1'b0, beat_cnt_q} + 1'b1;
  assign burst_done = xfer && (cnt_inc >= BURST_MAXW);
  assign cnt_next   = (cnt_inc >= BURST_MAXW) ? BURST_MAX : cnt_inc[ARB_CNT_W-1:0];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    grant_sel_d  = grant_sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid && req1_valid) state_d = last_grant_q ? ST_GNT0 : ST_GNT1;
        else if (req0_valid)          state_d = ST_GNT0;
        else if (req1_valid)          state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!req0_valid)                   state_d = req1_valid ? ST_GNT1 : ST_IDLE;
        else if (burst_done && req1_valid) state_d = ST_GNT1;
        else if (xfer)                     beat_cnt_d = cnt_next;
      end
      ST_GNT1: begin
        if (!req1_valid)                   state_d = req0_valid ? ST_GNT0 : ST_IDLE;
        else if (burst_done && req0_valid) state_d = ST_GNT0;
        else if (xfer)                     beat_cnt_d = cnt_next;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering a grant state restarts the burst and records the winner.
    if (state_d != state_q && state_d != ST_IDLE) begin
      last_grant_d = (state_d == ST_GNT1);
      beat_cnt_d   = '0;
    end

    // Select follows the grant state and holds its last value in IDLE.
    if (state_d == ST_GNT0)      grant_sel_d = 1'b0;
    else if (state_d == ST_GNT1) grant_sel_d = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = steered_data;
      out_src_d   = xfer1;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      grant_sel_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      // NOTE: the data word is reset too, since out_data must read 0 after
      // reset; it is a single register, not a memory array.
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_sel_q  <= grant_sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign grant_sel = grant_sel_q;

endmodule : mux_arbiter_2to1
